// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
// Coin values are expressed in half-yuan units.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    REFUND = 2'd3
  } vend_state_t;

  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;

  // Total value inserted in one cycle; both coins together give 3 units.
  function automatic logic [1:0] coin_value(input logic half, input logic one);
    return (half ? COIN_HALF : 2'd0) + (one ? COIN_ONE : 2'd0);
  endfunction

endpackage

// File: rtl/vend_refund_cnt.sv
// Loadable down-counter that holds the change still owed to the customer
// and produces the registered one-pulse-per-coin change output.
module vend_refund_cnt
  import vend_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         clr,
  input  logic         pulse_next,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         change
);

  // Change-owed register: clear beats load, load beats decrement.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Registered change pulse, high for every cycle spent paying out a coin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      change <= 1'b0;
    end else begin
      change <= pulse_next;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_fsm.sv
// Coin-operated vending controller: accumulates half/one-yuan coins, vends
// when the price is reached, then pays out any excess as half-unit pulses.
// Optional feature macro VEND_CANCEL_EN: pi_cancel refunds accumulated credit.
//
// Handshake: there is no valid/ready pair; every input is a single-cycle
// strobe sampled on the rising edge. While po_busy is high the strobes are
// dropped (coins are lost), and every output is a register.
module vend_fsm
  import vend_pkg::*;
#(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_change,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit,
  output logic [1:0]          dbg_state
);

  // Credit can momentarily reach PRICE-1+3 before a vend, so the counters
  // must hold PRICE+2.
  if ((PRICE < 1) || (PRICE > 60)) begin : g_bad_price
    $error("vend_fsm: PRICE %0d outside 1..60", PRICE);
  end
  if ((PRICE + 2) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vend_fsm: CREDIT_W %0d cannot hold PRICE+2 = %0d", CREDIT_W, PRICE + 2);
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_t         state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] load_val;
  logic [CREDIT_W-1:0] change_left;
  logic                load, dec, clr, pulse_next, cnt_zero;

`ifndef VEND_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = pi_cancel;
`endif

  assign sum = po_credit + CREDIT_W'(coin_value(pi_money_half, pi_money_one));

  // Next-state and counter-control decode; coins only count in IDLE/ACCUM.
  always_comb begin
    state_d    = state;
    credit_d   = po_credit;
    load       = 1'b0;
    load_val   = '0;
    dec        = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE, ACCUM: begin
`ifdef VEND_CANCEL_EN
        // Cancel wins over a coin that would otherwise complete the price.
        if (pi_cancel && (sum != '0)) begin
          state_d  = REFUND;
          credit_d = '0;
          load     = 1'b1;
          load_val = sum;
        end else
`endif
        if (sum >= PRICE_C) begin
          state_d  = VEND;
          credit_d = '0;
          load     = 1'b1;
          load_val = sum - PRICE_C;
        end else begin
          credit_d = sum;
          if (sum != '0) begin
            state_d = ACCUM;
          end
        end
      end
      VEND: begin
        credit_d = '0;
        state_d  = cnt_zero ? IDLE : REFUND;
      end
      REFUND: begin
        credit_d = '0;
        dec      = 1'b1;
        // The edge that pays the last coin also returns to IDLE.
        if (change_left <= CREDIT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
        clr      = 1'b1;
      end
    endcase
    pulse_next = (state_d == REFUND);
  end

  // State register plus registered vend/busy/credit outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      po_credit <= '0;
      po_cola   <= 1'b0;
      po_busy   <= 1'b0;
    end else begin
      state     <= state_d;
      po_credit <= credit_d;
      po_cola   <= (state_d == VEND);
      po_busy   <= (state_d == VEND) || (state_d == REFUND);
    end
  end

  vend_refund_cnt #(.W(CREDIT_W)) u_refund_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .dec        (dec),
    .clr        (clr),
    .pulse_next (pulse_next),
    .count      (change_left),
    .zero       (cnt_zero),
    .change     (po_change)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_vend_fsm.sv
// Self-checking bench for vend_fsm: directed scenarios with literal
// expectations plus randomized coins checked against a frame-queue model.
module tb_vend_fsm;
  import vend_pkg::*;

  localparam int PRICE = 5;
  localparam int CW    = 6;
  localparam int FW    = CW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          money_half = 1'b0, money_one = 1'b0, cancel = 1'b0;
  logic          cola, change, busy;
  logic [CW-1:0] credit;
  logic [1:0]    dbg;

  logic          h1 = 1'b0, o1 = 1'b0, c1 = 1'b0;
  logic          cola1, change1, busy1;
  logic [2:0]    credit1;
  logic [1:0]    dbg1;

  vend_fsm #(.PRICE(PRICE), .CREDIT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .pi_money_half(money_half), .pi_money_one(money_one),
    .pi_cancel(cancel), .po_cola(cola), .po_change(change), .po_busy(busy),
    .po_credit(credit), .dbg_state(dbg)
  );

  vend_fsm #(.PRICE(1), .CREDIT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pi_money_half(h1), .pi_money_one(o1),
    .pi_cancel(c1), .po_cola(cola1), .po_change(change1), .po_busy(busy1),
    .po_credit(credit1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of output frames {cola, change, busy, credit} still owed
  // after a purchase or cancel, plus the credit held while idle.
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_f = '0;
  int            m_credit = 0;

  function automatic logic [FW-1:0] mk(bit c, bit ch, bit b, int cr);
    return {c, ch, b, CW'(cr)};
  endfunction

  task automatic model_step();
    int sum;
    if (!rst_n) begin
      exp_q.delete();
      m_credit = 0;
      exp_f    = '0;
    end else if (exp_f[CW]) begin
      // Machine was busy during this cycle: inputs lost.
      exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : mk(0, 0, 0, 0);
    end else begin
      sum = m_credit + int'(money_half) + 2 * int'(money_one);
`ifdef VEND_CANCEL_EN
      if (cancel && sum > 0) begin
        m_credit = 0;
        repeat (sum) exp_q.push_back(mk(0, 1, 1, 0));
      end else
`endif
      if (sum >= PRICE) begin
        m_credit = 0;
        exp_q.push_back(mk(1, 0, 1, 0));
        repeat (sum - PRICE) exp_q.push_back(mk(0, 1, 1, 0));
      end else begin
        m_credit = sum;
      end
      exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : mk(0, 0, 0, m_credit);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cola", int'(cola), int'(exp_f[CW+2]));
      check("change", int'(change), int'(exp_f[CW+1]));
      check("busy", int'(busy), int'(exp_f[CW]));
      check("credit", int'(credit), int'(exp_f[CW-1:0]));
      check("cola_change_excl", int'(cola & change), 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Present one cycle of inputs; returns just after the edge that used them.
  task automatic cyc(input logic h, input logic o, input logic c);
    money_half = h;
    money_one  = o;
    cancel     = c;
    @(posedge clk);
    #1;
    money_half = 1'b0;
    money_one  = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    money_half = 1'b0;
    money_one  = 1'b0;
    cancel     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check("rst_cola", int'(cola), 0);
    check("rst_change", int'(change), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_credit", int'(credit), 0);
    check("rst_state", int'(dbg), int'(IDLE));
    check("rst1_credit", int'(credit1), 0);
    check("rst1_state", int'(dbg1), int'(IDLE));
    chk_en = 1'b1;

    // Five half coins: exact price, no change.
    repeat (4) cyc(1, 0, 0);
    check("half4_credit", int'(credit), 4);
    cyc(1, 0, 0);
    check("half5_cola", int'(cola), 1);
    check("half5_credit", int'(credit), 0);
    cyc(0, 0, 0);
    check("half5_after_cola", int'(cola), 0);
    check("half5_after_change", int'(change), 0);
    check("half5_after_busy", int'(busy), 0);

    // Three one-yuan coins: 6 units, one change pulse.
    repeat (3) cyc(0, 1, 0);
    check("one3_cola", int'(cola), 1);
    cyc(0, 0, 0);
    check("one3_change", int'(change), 1);
    check("one3_busy", int'(busy), 1);
    cyc(0, 0, 0);
    check("one3_done_change", int'(change), 0);
    check("one3_done_state", int'(dbg), int'(IDLE));

    // Credit 4 then both coins: 7 units, two change pulses; coins lost.
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("both_cola", int'(cola), 1);
    cyc(1, 1, 0);
    check("both_chg1", int'(change), 1);
    check("both_credit1", int'(credit), 0);
    cyc(1, 0, 0);
    check("both_chg2", int'(change), 1);
    cyc(0, 1, 0);
    check("both_idle_change", int'(change), 0);
    check("both_idle_credit", int'(credit), 0);
    cyc(0, 0, 0);
    check("both_coins_lost", int'(credit), 0);

    // Cancel with credit 3.
    do_reset();
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 1);
`ifdef VEND_CANCEL_EN
    check("cancel_chg1", int'(change), 1);
    check("cancel_cola", int'(cola), 0);
    check("cancel_credit", int'(credit), 0);
    cyc(0, 0, 0);
    check("cancel_chg2", int'(change), 1);
    cyc(0, 0, 0);
    check("cancel_chg3", int'(change), 1);
    cyc(0, 0, 0);
    check("cancel_done", int'(change), 0);
`else
    check("cancel_ignored_credit", int'(credit), 3);
    check("cancel_ignored_change", int'(change), 0);
`endif

    // Reset in the middle of a refund discards pending change.
    do_reset();
`ifdef VEND_CANCEL_EN
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
`else
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
`endif
    check("midref_change", int'(change), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midref_rst_change", int'(change), 0);
    check("midref_rst_busy", int'(busy), 0);
    check("midref_rst_cola", int'(cola), 0);
    check("midref_rst_state", int'(dbg), int'(IDLE));
    cyc(0, 0, 0);
    check("midref_no_more_change", int'(change), 0);

    // PRICE=1 instance: one coin of 2 units vends and returns one.
    o1 = 1'b1;
    @(posedge clk);
    #1;
    o1 = 1'b0;
    check("p1_cola", int'(cola1), 1);
    @(posedge clk);
    #1;
    check("p1_change", int'(change1), 1);
    check("p1_cola_off", int'(cola1), 0);
    @(posedge clk);
    #1;
    check("p1_done_change", int'(change1), 0);
    check("p1_done_busy", int'(busy1), 0);

    // Randomized coins, cancels and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 249) != 0);
      money_half = ($urandom_range(0, 2) == 0);
      money_one  = ($urandom_range(0, 3) == 0);
      cancel     = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    money_half = 1'b0;
    money_one  = 1'b0;
    cancel     = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
